adc_bcd_display: RTL and testbench

Downstream consumer of the scaled ADC millivolt value. On each load strobe it clamps the value to 0–9999 and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits onto the board's four-digit common-anode seven-segment display, with a fixed decimal point, so readings appear as volts (X.XXX).

---
 rtl/adc_bcd_display_if.sv | 21 ++
 rtl/adc_bcd_display.sv | 164 ++++++++++++++++
 tb/tb_adc_bcd_display.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_bcd_display_if.sv
// Conversion-side bus of adc_bcd_display: load strobe and value in,
// BCD result, status flags and busy out.
interface adc_bcd_display_if;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        over_range;
    logic        overrun;

    modport master (
        output load, value,
        input  busy, bcd, bcd_valid, over_range, overrun
    );

    modport slave (
        input  load, value,
        output busy, bcd, bcd_valid, over_range, overrun
    );
endinterface

// File: rtl/adc_bcd_display.sv
// Clamps a millivolt value to 0..9999, converts it to BCD with a sequential
// double-dabble engine and scans the digits onto a 4-digit common-anode display.
module adc_bcd_display #(
    parameter int DIGIT_REFRESH_COUNT = 100000,
    parameter int DP_POS              = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    adc_bcd_display_if.slave    conv,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                dp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                 CW           = (DIGIT_REFRESH_COUNT > 1) ? $clog2(DIGIT_REFRESH_COUNT) : 1;
    localparam logic [CW-1:0]      REFRESH_LAST = CW'(DIGIT_REFRESH_COUNT - 1);
    localparam logic [1:0]         DP_IDX       = 2'(DP_POS);
    localparam logic               DP_RESET     = (DP_POS == 0) ? 1'b0 : 1'b1;
    localparam logic [15:0]        VALUE_MAX    = 16'd9999;

    state_t      state_q;
    state_t      state_d;
    logic        start;
    logic        shift_en;
    logic        publish;

    logic [15:0] bin_q;
    logic [15:0] scratch_q;
    logic [15:0] scratch_adj;
    logic [4:0]  iter_q;
    logic        clamp_q;

    logic [CW-1:0] refresh_q;
    logic [1:0]    index_q;
    logic [3:0]    digit;

    // Conversion FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        publish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (conv.load) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (iter_q == 5'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction is applied before the shift in the same cycle.
    always_comb begin
        scratch_adj = scratch_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q           <= '0;
            scratch_q       <= '0;
            iter_q          <= '0;
            clamp_q         <= 1'b0;
            conv.bcd        <= '0;
            conv.bcd_valid  <= 1'b0;
            conv.over_range <= 1'b0;
            conv.overrun    <= 1'b0;
            conv.busy       <= 1'b0;
        end else begin
            conv.bcd_valid <= publish;
            conv.busy      <= (state_d != IDLE);
            if (conv.load && (state_q != IDLE)) begin
                conv.overrun <= 1'b1;
            end
            if (start) begin
                bin_q     <= (conv.value > VALUE_MAX) ? VALUE_MAX : conv.value;
                clamp_q   <= (conv.value > VALUE_MAX);
                scratch_q <= '0;
                iter_q    <= '0;
            end
            if (shift_en) begin
                scratch_q <= {scratch_adj[14:0], bin_q[15]};
                bin_q     <= {bin_q[14:0], 1'b0};
                iter_q    <= iter_q + 5'd1;
            end
            if (publish) begin
                conv.bcd        <= scratch_q;
                conv.over_range <= clamp_q;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign digit = conv.bcd[{index_q, 2'b00} +: 4];

    // Display scan runs continuously; outputs lag the index by one register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_q <= '0;
            index_q   <= '0;
            an        <= 4'b1110;
            seg       <= 7'h40;
            dp        <= DP_RESET;
        end else begin
            if (refresh_q == REFRESH_LAST) begin
                refresh_q <= '0;
                index_q   <= index_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
            an  <= ~(4'b0001 << index_q);
            seg <= seg_decode(digit);
            dp  <= (index_q != DP_IDX);
        end
    end

endmodule

// File: tb/tb_adc_bcd_display.sv
// Directed bench for adc_bcd_display: a cycle-level arithmetic model checked every
// cycle, plus literal expectations for latency, boundaries, overrun, scan and reset.
module tb_adc_bcd_display;

    localparam int N   = 4;
    localparam int DPP = 3;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    adc_bcd_display_if bus ();

    adc_bcd_display #(
        .DIGIT_REFRESH_COUNT(N),
        .DP_POS             (DPP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .conv   (bus.slave),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining-cycles counter for conversion, edge count for scan
    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int          m_rem     = 0;
    int unsigned m_pend    = 0;
    int          m_n       = 0;
    logic [15:0] m_bcd     = '0;
    logic        m_valid   = 1'b0;
    logic        m_ovr     = 1'b0;
    logic        m_overrun = 1'b0;
    logic [3:0]  e_an      = 4'b1110;
    logic [6:0]  e_seg     = 7'h40;
    logic        e_dp      = (DPP == 0) ? 1'b0 : 1'b1;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        int unsigned c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rem     = 0;
            m_n       = 0;
            m_bcd     = '0;
            m_valid   = 1'b0;
            m_ovr     = 1'b0;
            m_overrun = 1'b0;
            e_an      = 4'b1110;
            e_seg     = 7'h40;
            e_dp      = (DPP == 0) ? 1'b0 : 1'b1;
        end else begin
            int idx;
            idx   = (m_n / N) % 4;
            e_an  = ~(4'(1) << idx);
            e_seg = seg_tab[m_bcd[idx*4 +: 4]];
            e_dp  = (idx == DPP) ? 1'b0 : 1'b1;
            m_n++;
            m_valid = 1'b0;
            if (m_rem > 0) begin
                if (bus.load) m_overrun = 1'b1;
                m_rem--;
                if (m_rem == 0) begin
                    m_bcd   = to_bcd(m_pend);
                    m_ovr   = (m_pend > 9999);
                    m_valid = 1'b1;
                end
            end else if (bus.load) begin
                m_rem  = 17;
                m_pend = bus.value;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_busy",       bus.busy,       m_rem > 0);
            chk("m_bcd",        bus.bcd,        m_bcd);
            chk("m_bcd_valid",  bus.bcd_valid,  m_valid);
            chk("m_over_range", bus.over_range, m_ovr);
            chk("m_overrun",    bus.overrun,    m_overrun);
            chk("m_an",         an,             e_an);
            chk("m_seg",        seg,            e_seg);
            chk("m_dp",         dp,             e_dp);
        end
    end

    task automatic do_load(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = bus.busy ? 1 : 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bcnt++;
        end while (!bus.bcd_valid && cyc < 60);
        if (!bus.bcd_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_busy"},       bus.busy,       32'd0);
        chk({tag, "_bcd"},        bus.bcd,        32'h0000);
        chk({tag, "_bcd_valid"},  bus.bcd_valid,  32'd0);
        chk({tag, "_over_range"}, bus.over_range, 32'd0);
        chk({tag, "_overrun"},    bus.overrun,    32'd0);
        chk({tag, "_an"},         an,             32'hE);
        chk({tag, "_seg"},        seg,            32'h40);
        chk({tag, "_dp"},         dp,             32'd1);
    endtask

    logic [15:0] bv_in  [4] = '{16'd0, 16'd9999, 16'd10000, 16'd65535};
    logic [15:0] bv_exp [4] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
    logic        bv_ovr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  sc_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  sc_seg [4] = '{7'h79, 7'h78, 7'h40, 7'h30};
    logic        sc_dp  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int cyc;
        int bcnt;
        int h;
        int vc;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        reset_values("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        do_load(16'd1234);
        wait_valid(cyc, bcnt);
        chk("lat_1234",  cyc,            32'd17);
        chk("busy_1234", bcnt,           32'd17);
        chk("bcd_1234",  bus.bcd,        32'h1234);
        chk("ovr_1234",  bus.over_range, 32'd0);
        @(negedge clk);
        chk("valid_one_cycle", bus.bcd_valid, 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_load(bv_in[i]);
            wait_valid(cyc, bcnt);
            chk("bnd_bcd", bus.bcd,        {16'h0, bv_exp[i]});
            chk("bnd_ovr", bus.over_range, {31'h0, bv_ovr[i]});
            @(negedge clk);
        end
        chk("no_overrun_yet", bus.overrun, 32'd0);

        do_load(16'd5000);
        repeat (4) @(negedge clk);
        do_load(16'd42);
        wait_valid(cyc, bcnt);
        chk("bcd_5000",     bus.bcd,     32'h5000);
        chk("overrun_set",  bus.overrun, 32'd1);
        do_load(16'd3071);
        chk("load_on_valid_accepted", bus.busy, 32'd1);
        wait_valid(cyc, bcnt);
        chk("lat_3071",       cyc,         32'd17);
        chk("bcd_3071",       bus.bcd,     32'h3071);
        chk("overrun_sticky", bus.overrun, 32'd1);

        h = 0;
        while (an == 4'b1110 && h < 20) begin @(negedge clk); h++; end
        h = 0;
        while (an != 4'b1110 && h < 20) begin @(negedge clk); h++; end
        for (int d = 0; d < 4; d++) begin
            chk("scan_an",  an,  {28'h0, sc_an[d]});
            chk("scan_seg", seg, {25'h0, sc_seg[d]});
            chk("scan_dp",  dp,  {31'h0, sc_dp[d]});
            h = 0;
            while (an == sc_an[d] && h < 20) begin @(negedge clk); h++; end
            chk("scan_hold", h, N);
        end

        do_load(16'd1234);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 reset_values("abort");
        @(negedge clk);
        reset_n = 1'b1;
        vc = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.bcd_valid) vc++;
        end
        chk("no_valid_after_abort", vc,      32'd0);
        chk("bcd_after_abort",      bus.bcd, 32'h0000);

        do_load(16'd777);
        wait_valid(cyc, bcnt);
        chk("lat_777", cyc,     32'd17);
        chk("bcd_777", bus.bcd, 32'h0777);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
